// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, status flags and a result accumulator.
// Stage 1 holds the operands; stage 2 holds the result and flags presented downstream.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_q
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  // Returns {carry, ovf, y}; SUB and SLT share the A + ~B + 1 adder.
  function automatic logic [WIDTH+1:0] alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD: begin
        y = add_sum[WIDTH-1:0];
        c = add_sum[WIDTH];
        v = add_ovf;
      end
      OP_XOR:  y = a ^ b;
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      OP_SUB: begin
        y = sub_sum[WIDTH-1:0];
        c = sub_sum[WIDTH];
        v = sub_ovf;
      end
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
      default: y = '0;
    endcase
    return {c, v, y};
  endfunction

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_op_r;
  logic             s1_use_acc_r;
  logic             s2_valid_r;

  logic             s1_advance_s;
  logic             in_fire_s;
  logic [WIDTH-1:0] a_eff_s;
  logic [WIDTH-1:0] res_y_s;
  logic             res_carry_s;
  logic             res_ovf_s;

  assign s1_advance_s = s1_valid_r && (!s2_valid_r || out_ready);
  assign in_ready     = !rst && (!s1_valid_r || s1_advance_s);
  assign in_fire_s    = in_valid && in_ready;
  assign out_valid    = s2_valid_r;

  // The accumulator is read at compute time so back-to-back use_acc ops chain without forwarding.
  assign a_eff_s = s1_use_acc_r ? acc_q : s1_a_r;
  assign {res_carry_s, res_ovf_s, res_y_s} = alu_eval(a_eff_s, s1_b_r, s1_op_r);

  // Operand stage: capture on input handshake, drain when the result stage takes the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_a_r       <= '0;
      s1_b_r       <= '0;
      s1_op_r      <= 3'b000;
      s1_use_acc_r <= 1'b0;
    end else begin
      if (in_fire_s) begin
        s1_valid_r   <= 1'b1;
        s1_a_r       <= in_a;
        s1_b_r       <= in_b;
        s1_op_r      <= in_op;
        s1_use_acc_r <= in_use_acc;
      end else if (s1_advance_s) begin
        s1_valid_r <= 1'b0;
      end
    end
  end

  // Result stage and accumulator: load together when S1 advances, otherwise hold until retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      out_y      <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (s1_advance_s) begin
        s2_valid_r <= 1'b1;
        out_y      <= res_y_s;
        out_zero   <= (res_y_s == '0);
        out_neg    <= res_y_s[WIDTH-1];
        out_carry  <= res_carry_s;
        out_ovf    <= res_ovf_s;
        acc_q      <= res_y_s;
      end else if (s2_valid_r && out_ready) begin
        s2_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32) with hand-computed expectations.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        in_use_acc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_zero;
  logic        out_neg;
  logic        out_carry;
  logic        out_ovf;
  logic [31:0] acc_q;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_neg(out_neg),
    .out_carry(out_carry), .out_ovf(out_ovf), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp_zncv);
    chk(tag, {28'd0, out_zero, out_neg, out_carry, out_ovf}, {28'd0, exp_zncv});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_acc);
    in_valid   = 1'b1;
    in_op      = op;
    in_a       = a;
    in_b       = b;
    in_use_acc = use_acc;
  endtask

  // Issue one op with out_ready=1 and leave its result on the output stage.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_acc);
    drive(op, a, b, use_acc);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
    in_op = 3'b000; in_use_acc = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_acc", acc_q, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Flags are packed {zero, neg, carry, ovf}.
    issue(3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("add_wrap_valid", {31'd0, out_valid}, 32'd1);
    chk("add_wrap_y", out_y, 32'd0);
    chk_flags("add_wrap_flags", 4'b1010);
    issue(3'b010, 32'h7FFF_FFFF, 32'd1, 1'b0);
    chk("add_ovf_y", out_y, 32'h8000_0000);
    chk_flags("add_ovf_flags", 4'b0101);
    issue(3'b110, 32'h8000_0000, 32'd1, 1'b0);
    chk("sub_ovf_y", out_y, 32'h7FFF_FFFF);
    chk_flags("sub_ovf_flags", 4'b0011);
    issue(3'b110, 32'd1, 32'd2, 1'b0);
    chk("sub_borrow_y", out_y, 32'hFFFF_FFFF);
    chk_flags("sub_borrow_flags", 4'b0100);
    issue(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("slt_neg_y", out_y, 32'd1);
    chk_flags("slt_neg_flags", 4'b0000);
    issue(3'b111, 32'd1, 32'hFFFF_FFFF, 1'b0);
    chk("slt_pos_y", out_y, 32'd0);
    chk_flags("slt_pos_flags", 4'b1000);
    issue(3'b011, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    chk("xor_y", out_y, 32'h0F0F_F0F0);
    issue(3'b000, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    chk("and_y", out_y, 32'hF0F0_0000);
    issue(3'b001, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    chk("or_y", out_y, 32'hFFFF_F0F0);
    issue(3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    chk("andn_y", out_y, 32'h0000_F0F0);
    issue(3'b101, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    chk("orn_y", out_y, 32'hF0F0_FFFF);
    chk_flags("orn_flags", 4'b0100);
    tick();
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: the third ADD must wait until out_ready rises.
    out_ready = 1'b0;
    drive(3'b010, 32'd1, 32'd1, 1'b0);
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    drive(3'b010, 32'd2, 32'd2, 1'b0);
    chk("bp_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    drive(3'b010, 32'd3, 32'd3, 1'b0);
    chk("bp_ready3_blocked", {31'd0, in_ready}, 32'd0);
    chk("bp_first_y", out_y, 32'd2);
    tick();
    chk("bp_still_blocked", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_y", out_y, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_released", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_y", out_y, 32'd4);
    tick();
    chk("bp_third_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_third_y", out_y, 32'd6);
    tick();
    chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Accumulator chaining after a fresh reset.
    rst = 1'b1;
    tick();
    chk("acc_rst", acc_q, 32'd0);
    rst = 1'b0;
    tick();
    drive(3'b010, 32'hDEAD_BEEF, 32'd5, 1'b1);
    tick();
    tick();
    chk("acc_y1", out_y, 32'd5);
    tick();
    chk("acc_y2", out_y, 32'd10);
    in_valid = 1'b0;
    tick();
    chk("acc_y3", out_y, 32'd15);
    chk("acc_q15", acc_q, 32'd15);
    issue(3'b000, 32'd0, 32'h0000_000C, 1'b1);
    chk("acc_and_y", out_y, 32'h0000_000C);
    chk("acc_and_q", acc_q, 32'h0000_000C);
    tick();

    // Reset mid-stream discards both in-flight beats.
    out_ready = 1'b0;
    drive(3'b010, 32'd7, 32'd8, 1'b0);
    tick();
    drive(3'b010, 32'd1, 32'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_pre_acc", acc_q, 32'd15);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_acc", acc_q, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    issue(3'b010, 32'd3, 32'd4, 1'b0);
    chk("mid_next_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_next_y", out_y, 32'd7);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
